// File: rtl/fetch_unit.sv
// fetch_unit: program counter and IDLE/RUN/DONE launch control for the instruction ROM.
// Optional FETCH_CYCLE_COUNT_EN builds a saturating executed-instruction counter on CycleCnt.
module fetch_unit #(
  parameter int PC_W = 10,
  parameter logic [PC_W-1:0] TARG0 = PC_W'(0),
  parameter logic [PC_W-1:0] TARG1 = PC_W'(16),
  parameter logic [PC_W-1:0] TARG2 = PC_W'(32),
  parameter logic [PC_W-1:0] TARG3 = PC_W'(64)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] StartAddr,
  input  logic            Jump,
  input  logic            BranchEn,
  input  logic            Zero,
  input  logic [1:0]      TargSel,
  input  logic            Ack,
  output logic [PC_W-1:0] ProgCtr,
  output logic            Running,
  output logic            Done,
  output logic [31:0]     CycleCnt
);
  // One bit per visible state so Running and Done come straight from flops.
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  state_t state, state_d;
  logic [PC_W-1:0] pc_d, targ;
  logic launch, in_run;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_d;
  always_comb begin
    in_run = state == RUN;
    launch = state == IDLE && Start;
    targ = TargSel == 2'd0 ? TARG0 : TargSel == 2'd1 ? TARG1 : TargSel == 2'd2 ? TARG2 : TARG3;
    state_d = state == IDLE ? (Start ? RUN : IDLE) :
              in_run ? (Ack ? DONE : RUN) :
              (Start ? DONE : IDLE);
    pc_d = launch ? StartAddr :
           (!in_run || Ack) ? ProgCtr :
           (Jump || (BranchEn && Zero)) ? targ : ProgCtr + PC_W'(1);
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) ProgCtr <= '0;
    else ProgCtr <= pc_d;
  assign Running = state[0];
  assign Done = state[1];
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] cnt;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else if (launch) cnt <= '0;
    else if (in_run && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  assign CycleCnt = cnt;
`else
  assign CycleCnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural next-PC model.
module tb_fetch_unit;
  logic Clk = 0, Reset = 1, Start = 0, Jump = 0, BranchEn = 0, Zero = 0, Ack = 0;
  logic [9:0] StartAddr = '0, ProgCtr;
  logic [1:0] TargSel = '0;
  logic Running, Done;
  logic [31:0] CycleCnt;
  fetch_unit dut (.Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
                  .Jump(Jump), .BranchEn(BranchEn), .Zero(Zero), .TargSel(TargSel),
                  .Ack(Ack), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
                  .CycleCnt(CycleCnt));
  always #5 Clk = ~Clk;
  typedef struct {logic [9:0] pc; logic r; logic d; logic [31:0] c;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_pc = 0;
  bit m_run = 0, m_done = 0;
  longint m_cnt = 0;
  int targs[4] = '{0, 16, 32, 64};
  task automatic check(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".pc"}, ProgCtr, e.pc);
    check({tag, ".running"}, Running, e.r);
    check({tag, ".done"}, Done, e.d);
    check({tag, ".cnt"}, CycleCnt, e.c);
  endtask
  function automatic exp_t model_now();
    exp_t e;
    e.pc = m_pc[9:0];
    e.r = m_run;
    e.d = m_done;
`ifdef FETCH_CYCLE_COUNT_EN
    e.c = m_cnt[31:0];
`else
    e.c = 0;
`endif
    return e;
  endfunction
  task automatic model_reset();
    m_pc = 0; m_run = 0; m_done = 0; m_cnt = 0;
  endtask
  task automatic step(input bit s, input int a, input bit j, input bit b, input bit z,
                      input int t, input bit k);
    @(negedge Clk);
    Start = s; StartAddr = a[9:0]; Jump = j; BranchEn = b; Zero = z; TargSel = t[1:0]; Ack = k;
    if (m_run) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (k) begin m_run = 0; m_done = 1; end
      else if (j || (b && z)) m_pc = targs[t];
      else m_pc = (m_pc + 1) % 1024;
    end else if (m_done) begin
      if (!s) m_done = 0;
    end else if (s) begin
      m_run = 1; m_pc = a % 1024; m_cnt = 0;
    end
    q.push_back(model_now());
  endtask
  task automatic idle(input bit s, input int a);
    step(s, a, 0, 0, 0, 0, 0);
  endtask
  always @(posedge Clk) begin
    #1;
    if (q.size() > 0) check_all("edge", q.pop_front());
  end
  initial begin
    #12;
    check_all("reset", model_now());
    @(negedge Clk) Reset = 0;
    idle(1, 5);
    repeat (3) idle(1, $urandom);
    step(1, 0, 1, 0, 0, 2, 0);
    step(1, 0, 0, 1, 0, 3, 0);
    step(1, 0, 0, 1, 1, 3, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(0, 0);
    idle(1, 10'h3FE);
    repeat (2) idle(0, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    repeat (4) idle(1, 0);
    step(1, 0, 1, 0, 0, 3, 1);
    repeat (2) idle(1, 0);
    idle(0, 0);
    idle(1, 7);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);
    idle(1, 0);
    repeat (6) step(1, 0, 0, 1, 0, 2, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    repeat (2) idle(1, 0);
    idle(0, 0);
    idle(1, 38);
    repeat (2) idle(0, 0);
    @(posedge Clk);
    #3 Reset = 1;
    #1;
    model_reset();
    check_all("async_reset", model_now());
    @(negedge Clk) Reset = 0;
    repeat (3000)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 15) == 0);
    repeat (3) @(posedge Clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control decoder: it holds the program counter that addresses the instruction ROM. It consumes the decoder's Jump, BranchEn, TargSel and Ack outputs, plus the ALU Zero flag, to compute the next program counter. It also owns the start/done handshake with the testbench through an IDLE/RUN/DONE state machine.

## Interface
- PC_W, 10: program counter width; the ROM depth is 2^PC_W.
- TARG0, 10'd0: absolute branch/jump target selected by TargSel=0.
- TARG1, 10'd16: target for TargSel=1.
- TARG2, 10'd32: target for TargSel=2.
- TARG3, 10'd64: target for TargSel=3.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  level request to run a program.
- StartAddr  in  PC_W  first instruction address, sampled on launch.
- Jump  in  1  unconditional jump from the decoder.
- BranchEn  in  1  conditional branch from the decoder.
- Zero  in  1  ALU zero flag qualifying BranchEn.
- TargSel  in  2  target LUT index from the decoder.
- Ack  in  1  end-of-program from the decoder.
- ProgCtr  out  PC_W  registered instruction address to the ROM.
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.
- CycleCnt  out  32  count of executed instructions (see Configuration).

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - Running=0, Done=0, ProgCtr holds.
  - Start=1 -> RUN with ProgCtr<=StartAddr and CycleCnt<=0.
- RUN: ProgCtr addresses the instruction currently being decoded. Next-PC priority:
  - Ack=1 -> DONE, ProgCtr holds.
  - Else Jump=1 -> ProgCtr<=TARGn, where n=TargSel.
  - Else BranchEn=1 and Zero=1 -> ProgCtr<=TARGn.
  - Else ProgCtr<=ProgCtr+1, modulo 2^PC_W; 2^PC_W-1 wraps to 0.
- Start is ignored while in RUN.
- BranchEn=1 with Zero=0 is a fall-through: ProgCtr+1.
- DONE:
  - Done=1, ProgCtr holds.
  - Start=0 -> IDLE.
  - Start=1 -> remain in DONE. No relaunch occurs until Start drops and rises again.
- Decoder inputs (Jump, BranchEn, Zero, TargSel, Ack) are ignored outside RUN.
- Reset in any state, including mid-RUN, immediately forces: IDLE, ProgCtr=0, Running=0, Done=0, CycleCnt=0.

## Timing
- Reset values: ProgCtr=0, Running=0, Done=0, CycleCnt=0, state=IDLE.
- ROM and decoder are combinational. All decoder inputs are sampled at the same Clk edge that updates ProgCtr; there is zero bubble between instructions.
- Launch latency is 1 cycle: Start is seen at edge k; ProgCtr=StartAddr and Running=1 after edge k.
- Taken jump/branch latency is 1 cycle: the target instruction is presented immediately after the edge.
- Ack seen at edge k: Running=0 and Done=1 after edge k. The Ack instruction's address stays on ProgCtr.
- Running and Done are registered state decodes and are never both high.

## Configuration
- FETCH_CYCLE_COUNT_EN defined:
  - CycleCnt increments by 1 on every edge taken in RUN, including the Ack edge.
  - It clears at launch and saturates at 32'hFFFF_FFFF.
  - It holds its value in DONE and IDLE.
- FETCH_CYCLE_COUNT_EN undefined: CycleCnt is tied to 0 and no counter flops are built.

## Test plan
- Reset, then Start=1 with StartAddr=5 and no control inputs for 3 cycles:
  - ProgCtr goes 5, 6, 7, 8 with Running=1.
- In RUN at ProgCtr=8:
  - Jump=1, TargSel=2 -> next ProgCtr=32.
  - Then BranchEn=1, Zero=0, TargSel=3 -> 33.
  - Then BranchEn=1, Zero=1, TargSel=3 -> 64.
- StartAddr=10'h3FE, run 2 cycles -> ProgCtr 3FE, 3FF, 000 (wrap).
- Ack=1 and Jump=1 together at ProgCtr=20:
  - Done=1, Running=0, ProgCtr stays 20.
  - With Start still 1, the block stays in DONE.
  - Start=0 -> IDLE; Start=1 again relaunches at StartAddr.
- Assert Reset asynchronously mid-RUN at ProgCtr=40, between edges:
  - ProgCtr=0, Running=0, Done=0 immediately, without waiting for a Clk edge.
- With FETCH_CYCLE_COUNT_EN: launch at 0, Ack on the 7th instruction -> CycleCnt=7 held in DONE.
- Without FETCH_CYCLE_COUNT_EN: CycleCnt=0 throughout.
